// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take DWIDTH radix-2 steps plus one sign-fixup cycle.
module ex_muldiv_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mdvalidin,
  input  logic              flushin,
  input  logic [5:0]        functin,
  input  logic [DWIDTH-1:0] regdata1in,
  input  logic [DWIDTH-1:0] regdata2in,
  output logic              stallout,
  output logic              busyout,
  output logic [DWIDTH-1:0] hiout,
  output logic [DWIDTH-1:0] loout,
  output logic [DWIDTH-1:0] rddataout
);

  localparam int unsigned CW = $clog2(DWIDTH);

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DWIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DWIDTH-1:0] opb_q, opb_d, dvd_q, dvd_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d, sa_q, sa_d, dz_q, dz_d;
  logic              busy_q, busy_d;

  logic              issue, is_start, is_class, op_signed;
  logic              a_neg, b_neg;
  logic [DWIDTH-1:0] a_mag, b_mag, add_term;
  logic [DWIDTH:0]   sum, shifted, diff;
  logic [2*DWIDTH-1:0] prod;

  // Decode of the EX instruction
  always_comb begin
    issue     = mdvalidin & ~flushin;
    is_start  = (functin[5:2] == 4'b0110);
    is_class  = is_start | (functin[5:2] == 4'b0100);
    op_signed = ~functin[0];
    a_neg     = op_signed & regdata1in[DWIDTH-1];
    b_neg     = op_signed & regdata2in[DWIDTH-1];
    a_mag     = a_neg ? DWIDTH'(-regdata1in) : regdata1in;
    b_mag     = b_neg ? DWIDTH'(-regdata2in) : regdata2in;
    stallout  = issue & is_class & (state_q != S_IDLE);
    case (functin)
      F_MFHI:  rddataout = hi_q;
      F_MFLO:  rddataout = lo_q;
      default: rddataout = '0;
    endcase
  end

  // Datapath for one multiply or divide step and the final sign fixup
  always_comb begin
    add_term = acc_lo_q[0] ? opb_q : '0;
    sum      = {1'b0, acc_hi_q} + {1'b0, add_term};
    shifted  = {acc_hi_q, acc_lo_q[DWIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    prod     = {acc_hi_q, acc_lo_q};
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    dvd_d    = dvd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (issue && is_start) begin
          state_d  = S_RUN;
          count_d  = '0;
          is_div_d = functin[1];
          neg_d    = a_neg ^ b_neg;
          sa_d     = a_neg;
          dz_d     = (regdata2in == '0);
          dvd_d    = regdata1in;
          acc_hi_d = '0;
          // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier out
          acc_lo_d = functin[1] ? a_mag : b_mag;
          opb_d    = functin[1] ? b_mag : a_mag;
        end else if (issue && functin == F_MTHI) begin
          hi_d = regdata1in;
        end else if (issue && functin == F_MTLO) begin
          lo_d = regdata1in;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!diff[DWIDTH]) begin
            acc_hi_d = diff[DWIDTH-1:0];
            acc_lo_d = {acc_lo_q[DWIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = shifted[DWIDTH-1:0];
            acc_lo_d = {acc_lo_q[DWIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = sum[DWIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[DWIDTH-1:1]};
        end
        count_d = CW'(count_q + 1'b1);
        if (count_q == CW'(DWIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_q ? (2*DWIDTH)'(-prod) : prod;
        end else if (dz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q ? DWIDTH'(-acc_lo_q) : acc_lo_q;
          hi_d = sa_q ? DWIDTH'(-acc_hi_q) : acc_hi_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      dvd_q    <= dvd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
    end
  end

  assign busyout = busy_q;
  assign hiout   = hi_q;
  assign loout   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed mult/div vectors, stall, flush and reset cases.
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, mdvalidin, flushin;
  logic [5:0]   functin;
  logic [W-1:0] regdata1in, regdata2in;
  logic         stallout, busyout;
  logic [W-1:0] hiout, loout, rddataout;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  ex_muldiv_unit #(.DWIDTH(W)) dut (
    .clk(clk), .rst(rst), .mdvalidin(mdvalidin), .flushin(flushin),
    .functin(functin), .regdata1in(regdata1in), .regdata2in(regdata2in),
    .stallout(stallout), .busyout(busyout), .hiout(hiout), .loout(loout),
    .rddataout(rddataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Monitor: a busy->idle transition not caused by reset presents a finished result
  initial begin : monitor
    logic prev_busy, prev_rst;
    exp_t e;
    prev_busy = 1'b0;
    prev_rst  = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_busy && !busyout && !prev_rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, 64'(hiout), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(loout), 64'(e.lo));
        end
      end
      prev_busy = busyout;
      prev_rst  = rst;
    end
  end

  // Present an instruction in EX, hold it while stalled; returns the number of stalled cycles
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fl, output int stalls);
    stalls     = 0;
    mdvalidin  = 1'b1;
    flushin    = fl;
    functin    = f;
    regdata1in = a;
    regdata2in = b;
    @(negedge clk);
    while (stallout && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (stallout) chk("stall_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    mdvalidin = 1'b0;
    flushin   = 1'b0;
    functin   = 6'h00;
  endtask

  // Count cycles with busyout high until the unit returns to idle
  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    while (busyout && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (busyout) chk("done_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int s, bc;
    exp_q.push_back('{name, ehi, elo});
    issue(f, a, b, 1'b0, s);
    wait_done(bc);
    chk({name, "_busy_cycles"}, 64'(bc), 64'd33);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s, bc;
    rst = 1'b1; mdvalidin = 1'b0; flushin = 1'b0; functin = 6'h00;
    regdata1in = '0; regdata2in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(hiout), 64'd0);
    chk("reset_lo", 64'(loout), 64'd0);
    chk("reset_busy", 64'(busyout), 64'd0);
    chk("reset_stall", 64'(stallout), 64'd0);
    @(posedge clk); #1;

    run_op("mult_neg3x7",  6'h18, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",    6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu_100_7",   6'h1B, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_neg7_2",   6'h1A, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_overflow", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    run_op("divu_5_0",     6'h1B, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    run_op("div_neg8_0",   6'h1A, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op("mult_neg5xneg4", 6'h18, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'h0,       32'd20);

    // MFLO one bubble after MULT 6*7: stalls for the remaining 32 busy cycles
    exp_q.push_back('{"mult_6x7", 32'h0, 32'd42});
    mdvalidin = 1'b1; functin = 6'h18; regdata1in = 32'd6; regdata2in = 32'd7;
    @(posedge clk); #1;
    mdvalidin = 1'b0; functin = 6'h00;
    @(posedge clk); #1;
    mdvalidin = 1'b1; functin = 6'h12;
    @(negedge clk);
    s = 0;
    while (stallout && s < 100) begin
      s++;
      @(negedge clk);
    end
    chk("mflo_stall_cycles", 64'(s), 64'd32);
    chk("mflo_rddata", 64'(rddataout), 64'd42);
    @(posedge clk); #1;
    mdvalidin = 1'b0; functin = 6'h00;

    // Second MULTU issued right after the first is accepted waits out all 33 busy cycles
    exp_q.push_back('{"multu_3x4", 32'h0, 32'd12});
    exp_q.push_back('{"multu_5x6", 32'h0, 32'd30});
    issue(6'h19, 32'd3, 32'd4, 1'b0, s);
    chk("first_mul_stall", 64'(s), 64'd0);
    issue(6'h19, 32'd5, 32'd6, 1'b0, s);
    chk("second_mul_stall", 64'(s), 64'd33);
    wait_done(bc);

    // Move-to HI/LO, flushed move, and reads
    issue(6'h11, 32'hABCD, 32'h0, 1'b0, s);
    chk("mthi", 64'(hiout), 64'hABCD);
    issue(6'h11, 32'h1234, 32'h0, 1'b1, s);
    chk("mthi_flushed", 64'(hiout), 64'hABCD);
    issue(6'h13, 32'h55, 32'h0, 1'b0, s);
    chk("mtlo", 64'(loout), 64'h55);
    functin = 6'h10;
    #1 chk("mfhi_rddata", 64'(rddataout), 64'hABCD);
    functin = 6'h00;

    // A flushed MULT starts nothing
    issue(6'h18, 32'd9, 32'd9, 1'b1, s);
    @(negedge clk);
    chk("flushed_mult_busy", 64'(busyout), 64'd0);
    chk("flushed_mult_lo", 64'(loout), 64'h55);
    @(posedge clk); #1;

    // Reset during RUN cycle 10 of a DIV aborts it
    issue(6'h1A, 32'd1000, 32'd3, 1'b0, s);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mdvalidin = 1'b1; functin = 6'h10;
    @(negedge clk);
    chk("abort_busy", 64'(busyout), 64'd0);
    chk("abort_hi", 64'(hiout), 64'd0);
    chk("abort_lo", 64'(loout), 64'd0);
    chk("abort_stall", 64'(stallout), 64'd0);
    @(posedge clk); #1;
    mdvalidin = 1'b0; functin = 6'h00;

    repeat (3) @(posedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
